// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter family: FSM state encoding
// and the width derivations used by the arbiter and its picker.
package dmem_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Byte-enable width for a given data width.
   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

   // Width of a master index; never below one bit.
   function automatic int idx_width(input int num_masters);
      return (num_masters > 1) ? $clog2(num_masters) : 1;
   endfunction

   // Width of the memory wait counter; a 1-bit stub when the timeout is disabled.
   function automatic int cnt_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational one-hot request picker. In round-robin mode the search starts
// just after the previous winner and wraps; in fixed mode index 0 is highest.
module rr_priority_picker
   import dmem_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int RR_MODE     = 1,
   parameter int IDX_W       = 2
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       last_grant,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [IDX_W-1:0]       grant_idx
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   // Walk the candidates in priority order and keep the first requester.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int off = 0; off < NUM_MASTERS; off++) begin
         if (RR_MODE != 0) begin
            cand = (int'(last_grant) + 1 + off) % NUM_MASTERS;
         end else begin
            cand = off;
         end
         cand_idx = IDX_W'(cand);
         if ((found == 1'b0) && (req[cand_idx] == 1'b1)) begin
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
            found           = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// N-master data-memory arbiter. One transaction at a time: IDLE picks a
// master and latches its request onto the memory port, BUSY waits for the
// memory (or the optional timeout), RESP returns a one-cycle Ready or Error.
module dmem_rr_arbiter
   import dmem_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 30,
   parameter int DATA_WIDTH  = 32,
   parameter int RR_MODE     = 1,
   parameter int TIMEOUT     = 0
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [NUM_MASTERS-1:0]                M_DataMem_Read,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] M_DataMem_Write,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     M_DataMem_Address,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     M_DataMem_Out,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0]     M_DataMem_In,
   output logic [NUM_MASTERS-1:0]                M_DataMem_Ready,
   output logic [NUM_MASTERS-1:0]                M_DataMem_Error,
   output logic                                  Mem_DataMem_Read,
   output logic [DATA_WIDTH/8-1:0]               Mem_DataMem_Write,
   output logic [ADDR_WIDTH-1:0]                 Mem_DataMem_Address,
   output logic [DATA_WIDTH-1:0]                 Mem_DataMem_Out,
   input  logic [DATA_WIDTH-1:0]                 Mem_DataMem_In,
   input  logic                                  Mem_DataMem_Ready
);

   localparam int BE_WIDTH = be_width(DATA_WIDTH);
   localparam int IDX_W    = idx_width(NUM_MASTERS);
   localparam int CNT_W    = cnt_width(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   // Per-master views of the flat buses.
   logic [NUM_MASTERS-1:0] req;
   logic [BE_WIDTH-1:0]    wr_arr   [NUM_MASTERS];
   logic [ADDR_WIDTH-1:0]  addr_arr [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  out_arr  [NUM_MASTERS];

   // State and registered outputs.
   arb_state_e             state_r, state_nxt;
   logic [IDX_W-1:0]       grant_r, grant_nxt;
   logic [IDX_W-1:0]       last_grant_r, last_grant_nxt;
   logic [CNT_W-1:0]       wait_cnt_r, wait_cnt_nxt;
   logic                   mem_read_r, mem_read_nxt;
   logic [BE_WIDTH-1:0]    mem_write_r, mem_write_nxt;
   logic [ADDR_WIDTH-1:0]  mem_addr_r, mem_addr_nxt;
   logic [DATA_WIDTH-1:0]  mem_out_r, mem_out_nxt;
   logic [NUM_MASTERS-1:0] m_ready_r, m_ready_nxt;
   logic [NUM_MASTERS-1:0] m_error_r, m_error_nxt;
   logic [DATA_WIDTH-1:0]  in_r   [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  in_nxt [NUM_MASTERS];

   logic [NUM_MASTERS-1:0] pick_grant;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_any;
   logic                   timeout_hit;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
      assign wr_arr[i]   = M_DataMem_Write[i*BE_WIDTH +: BE_WIDTH];
      assign addr_arr[i] = M_DataMem_Address[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign out_arr[i]  = M_DataMem_Out[i*DATA_WIDTH +: DATA_WIDTH];
      assign req[i]      = M_DataMem_Read[i] | (|wr_arr[i]);
      assign M_DataMem_In[i*DATA_WIDTH +: DATA_WIDTH] = in_r[i];
   end

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .RR_MODE     (RR_MODE),
      .IDX_W       (IDX_W)
   ) u_picker (
      .req        (req),
      .last_grant (last_grant_r),
      .grant      (pick_grant),
      .grant_idx  (pick_idx)
   );

   assign pick_any = |pick_grant;

   assign Mem_DataMem_Read    = mem_read_r;
   assign Mem_DataMem_Write   = mem_write_r;
   assign Mem_DataMem_Address = mem_addr_r;
   assign Mem_DataMem_Out     = mem_out_r;
   assign M_DataMem_Ready     = m_ready_r;
   assign M_DataMem_Error     = m_error_r;

   // Timeout fires once the wait counter has reached the configured limit.
   always_comb begin
      if (TIMEOUT > 0) begin
         timeout_hit = (wait_cnt_r == CNT_W'(TIMEOUT));
      end else begin
         timeout_hit = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ARB_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // FSM next-state logic; memory Ready has priority over the timeout.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_any) begin
               state_nxt = ARB_BUSY;
            end else begin
               state_nxt = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (Mem_DataMem_Ready || timeout_hit) begin
               state_nxt = ARB_RESP;
            end else begin
               state_nxt = ARB_BUSY;
            end
         end
         ARB_RESP: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   // Output/datapath next values: request mux on grant, response demux on completion.
   always_comb begin
      grant_nxt      = grant_r;
      last_grant_nxt = last_grant_r;
      wait_cnt_nxt   = wait_cnt_r;
      mem_read_nxt   = mem_read_r;
      mem_write_nxt  = mem_write_r;
      mem_addr_nxt   = mem_addr_r;
      mem_out_nxt    = mem_out_r;
      m_ready_nxt    = '0;
      m_error_nxt    = '0;
      in_nxt         = in_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_nxt      = pick_idx;
               last_grant_nxt = pick_idx;
               wait_cnt_nxt   = '0;
               // A write enable on the same master overrides its read.
               mem_read_nxt   = M_DataMem_Read[pick_idx] & ~(|wr_arr[pick_idx]);
               mem_write_nxt  = wr_arr[pick_idx];
               mem_addr_nxt   = addr_arr[pick_idx];
               mem_out_nxt    = out_arr[pick_idx];
            end else begin
               mem_read_nxt   = 1'b0;
               mem_write_nxt  = '0;
               mem_addr_nxt   = '0;
               mem_out_nxt    = '0;
            end
         end
         ARB_BUSY: begin
            if (Mem_DataMem_Ready) begin
               if (mem_read_r) begin
                  in_nxt[grant_r] = Mem_DataMem_In;
               end else begin
                  in_nxt[grant_r] = in_r[grant_r];
               end
               m_ready_nxt[grant_r] = 1'b1;
               mem_read_nxt  = 1'b0;
               mem_write_nxt = '0;
               mem_addr_nxt  = '0;
               mem_out_nxt   = '0;
            end else if (timeout_hit) begin
               m_error_nxt[grant_r] = 1'b1;
               mem_read_nxt  = 1'b0;
               mem_write_nxt = '0;
               mem_addr_nxt  = '0;
               mem_out_nxt   = '0;
            end else if (TIMEOUT > 0) begin
               wait_cnt_nxt = wait_cnt_r + CNT_W'(1);
            end else begin
               wait_cnt_nxt = wait_cnt_r;
            end
         end
         ARB_RESP: begin
            mem_read_nxt = 1'b0;
         end
         default: begin
            mem_read_nxt  = 1'b0;
            mem_write_nxt = '0;
            mem_addr_nxt  = '0;
            mem_out_nxt   = '0;
         end
      endcase
   end

   // Datapath and output registers; reset abandons any in-flight transaction.
   always_ff @(posedge clock) begin
      if (reset) begin
         grant_r      <= '0;
         last_grant_r <= LAST_IDX;
         wait_cnt_r   <= '0;
         mem_read_r   <= 1'b0;
         mem_write_r  <= '0;
         mem_addr_r   <= '0;
         mem_out_r    <= '0;
         m_ready_r    <= '0;
         m_error_r    <= '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            in_r[i] <= '0;
         end
      end else begin
         grant_r      <= grant_nxt;
         last_grant_r <= last_grant_nxt;
         wait_cnt_r   <= wait_cnt_nxt;
         mem_read_r   <= mem_read_nxt;
         mem_write_r  <= mem_write_nxt;
         mem_addr_r   <= mem_addr_nxt;
         mem_out_r    <= mem_out_nxt;
         m_ready_r    <= m_ready_nxt;
         m_error_r    <= m_error_nxt;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            in_r[i] <= in_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter: a cycle table for the basic read/write
// paths, then hand sequences for fairness, fixed priority, timeout and reset.
module tb_dmem_rr_arbiter;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   m_read;
   logic [15:0]  m_write;
   logic [119:0] m_addr;
   logic [127:0] m_out;
   logic [31:0]  mem_in;
   logic         mem_rdy;

   logic [127:0] rr_in,  fp_in;
   logic [3:0]   rr_rdy, fp_rdy, rr_err, fp_err, rr_mwr, fp_mwr;
   logic         rr_mrd, fp_mrd;
   logic [29:0]  rr_maddr, fp_maddr;
   logic [31:0]  rr_mout, fp_mout;

   logic [29:0]  a_tab [4];
   logic [31:0]  o_tab [4];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   dmem_rr_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(30), .DATA_WIDTH(32), .RR_MODE(1), .TIMEOUT(8)) u_rr (
      .clock(clock), .reset(reset),
      .M_DataMem_Read(m_read), .M_DataMem_Write(m_write),
      .M_DataMem_Address(m_addr), .M_DataMem_Out(m_out),
      .M_DataMem_In(rr_in), .M_DataMem_Ready(rr_rdy), .M_DataMem_Error(rr_err),
      .Mem_DataMem_Read(rr_mrd), .Mem_DataMem_Write(rr_mwr),
      .Mem_DataMem_Address(rr_maddr), .Mem_DataMem_Out(rr_mout),
      .Mem_DataMem_In(mem_in), .Mem_DataMem_Ready(mem_rdy)
   );

   dmem_rr_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(30), .DATA_WIDTH(32), .RR_MODE(0), .TIMEOUT(0)) u_fp (
      .clock(clock), .reset(reset),
      .M_DataMem_Read(m_read), .M_DataMem_Write(m_write),
      .M_DataMem_Address(m_addr), .M_DataMem_Out(m_out),
      .M_DataMem_In(fp_in), .M_DataMem_Ready(fp_rdy), .M_DataMem_Error(fp_err),
      .Mem_DataMem_Read(fp_mrd), .Mem_DataMem_Write(fp_mwr),
      .Mem_DataMem_Address(fp_maddr), .Mem_DataMem_Out(fp_mout),
      .Mem_DataMem_In(mem_in), .Mem_DataMem_Ready(mem_rdy)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  rd;
      logic [15:0] wr;
      logic        mrdy;
      logic [31:0] min;
      logic        erd;
      logic [3:0]  ewr;
      logic [29:0] eaddr;
      logic [31:0] eout;
      logic [3:0]  erdy;
      logic [3:0]  eerr;
      int          sidx;
      logic [31:0] sval;
   } vec_t;

   localparam int NV = 16;
   vec_t vec [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      m_read  = 4'h0;
      m_write = 16'h0;
      mem_rdy = 1'b0;
      mem_in  = 32'h0;
      tick();
      reset   = 1'b0;
   endtask

   // Wait (bounded) for the chosen instance to drive a memory read.
   task automatic wait_grant(input string name, input bit use_fp, input int budget);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (!ok) begin
            tick();
            if ((use_fp && fp_mrd) || (!use_fp && rr_mrd)) ok = 1'b1;
         end
      end
      chk(name, {63'd0, ok}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      a_tab[0] = 30'h040; a_tab[1] = 30'h080; a_tab[2] = 30'h100; a_tab[3] = 30'h1C0;
      o_tab[0] = 32'h12345678; o_tab[1] = 32'hA5A50001;
      o_tab[2] = 32'hA5A50002; o_tab[3] = 32'hA5A50003;
      for (int i = 0; i < 4; i++) begin
         m_addr[i*30 +: 30] = a_tab[i];
         m_out[i*32 +: 32]  = o_tab[i];
      end

      //           rst   rd     wr        mrdy  min            erd   ewr    eaddr      eout           erdy   eerr  sidx sval
      vec[0]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0, 30'h000, 32'h0,        4'h0, 4'h0, 2, 32'h0};
      vec[1]  = '{1'b0, 4'h4, 16'h0000, 1'b0, 32'h0,        1'b1, 4'h0, 30'h100, 32'hA5A50002, 4'h0, 4'h0, 2, 32'h0};
      vec[2]  = '{1'b0, 4'h4, 16'h0000, 1'b0, 32'h0,        1'b1, 4'h0, 30'h100, 32'hA5A50002, 4'h0, 4'h0, 2, 32'h0};
      vec[3]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 32'h0,        1'b1, 4'h0, 30'h100, 32'hA5A50002, 4'h0, 4'h0, 2, 32'h0};
      vec[4]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 32'hDEADBEEF, 1'b0, 4'h0, 30'h000, 32'h0,        4'h4, 4'h0, 2, 32'hDEADBEEF};
      vec[5]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0, 30'h000, 32'h0,        4'h0, 4'h0, 2, 32'hDEADBEEF};
      vec[6]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 32'h11111111, 1'b0, 4'h0, 30'h000, 32'h0,        4'h0, 4'h0, 2, 32'hDEADBEEF};
      vec[7]  = '{1'b0, 4'h0, 16'h0003, 1'b0, 32'h0,        1'b0, 4'h3, 30'h040, 32'h12345678, 4'h0, 4'h0, 0, 32'h0};
      vec[8]  = '{1'b0, 4'h0, 16'h0003, 1'b1, 32'hCAFEF00D, 1'b0, 4'h0, 30'h000, 32'h0,        4'h1, 4'h0, 0, 32'h0};
      vec[9]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0, 30'h000, 32'h0,        4'h0, 4'h0, 0, 32'h0};
      vec[10] = '{1'b0, 4'h2, 16'h00F0, 1'b0, 32'h0,        1'b0, 4'hF, 30'h080, 32'hA5A50001, 4'h0, 4'h0, 1, 32'h0};
      vec[11] = '{1'b0, 4'h2, 16'h00F0, 1'b1, 32'h00000055, 1'b0, 4'h0, 30'h000, 32'h0,        4'h2, 4'h0, 1, 32'h0};
      vec[12] = '{1'b0, 4'h0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0, 30'h000, 32'h0,        4'h0, 4'h0, 1, 32'h0};
      vec[13] = '{1'b0, 4'h8, 16'h0000, 1'b0, 32'h0,        1'b1, 4'h0, 30'h1C0, 32'hA5A50003, 4'h0, 4'h0, 3, 32'h0};
      vec[14] = '{1'b0, 4'h8, 16'h0000, 1'b1, 32'h0BADF00D, 1'b0, 4'h0, 30'h000, 32'h0,        4'h8, 4'h0, 3, 32'h0BADF00D};
      vec[15] = '{1'b0, 4'h0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0, 30'h000, 32'h0,        4'h0, 4'h0, 2, 32'hDEADBEEF};

      // Cycle table: inputs before an edge, outputs just after it.
      for (int k = 0; k < NV; k++) begin
         reset   = vec[k].rst;
         m_read  = vec[k].rd;
         m_write = vec[k].wr;
         mem_rdy = vec[k].mrdy;
         mem_in  = vec[k].min;
         tick();
         chk($sformatf("v%0d_mem_read", k),  {63'd0, rr_mrd},   {63'd0, vec[k].erd});
         chk($sformatf("v%0d_mem_write", k), {60'd0, rr_mwr},   {60'd0, vec[k].ewr});
         chk($sformatf("v%0d_mem_addr", k),  {34'd0, rr_maddr}, {34'd0, vec[k].eaddr});
         chk($sformatf("v%0d_mem_out", k),   {32'd0, rr_mout},  {32'd0, vec[k].eout});
         chk($sformatf("v%0d_ready", k),     {60'd0, rr_rdy},   {60'd0, vec[k].erdy});
         chk($sformatf("v%0d_error", k),     {60'd0, rr_err},   {60'd0, vec[k].eerr});
         chk($sformatf("v%0d_in_slice", k),  {32'd0, rr_in[vec[k].sidx*32 +: 32]}, {32'd0, vec[k].sval});
      end

      // Round-robin fairness with all masters requesting continuously.
      do_reset();
      m_read = 4'hF;
      for (int k = 0; k < 5; k++) begin
         wait_grant($sformatf("rr%0d_wait", k), 1'b0, 6);
         chk($sformatf("rr%0d_addr", k), {34'd0, rr_maddr}, {34'd0, a_tab[k % 4]});
         mem_rdy = 1'b1;
         mem_in  = 32'h1000 + 32'(k);
         tick();
         mem_rdy = 1'b0;
         chk($sformatf("rr%0d_ready", k), {60'd0, rr_rdy}, {60'd0, 4'h1 << (k % 4)});
         chk($sformatf("rr%0d_slice", k), {32'd0, rr_in[(k % 4)*32 +: 32]}, {32'd0, 32'h1000 + 32'(k)});
         tick();
         chk($sformatf("rr%0d_ready_drop", k), {60'd0, rr_rdy}, 64'd0);
      end

      // Fixed priority: 1 beats 3; then 0 keeps winning while RR moves to 2.
      do_reset();
      m_read = 4'b1010;
      wait_grant("fp_wait1", 1'b1, 4);
      chk("fp_first_addr", {34'd0, fp_maddr}, {34'd0, a_tab[1]});
      mem_rdy = 1'b1; mem_in = 32'h0000A001;
      tick();
      mem_rdy = 1'b0;
      chk("fp_first_ready", {60'd0, fp_rdy}, 64'h2);
      m_read = 4'b1000;
      wait_grant("fp_wait3", 1'b1, 6);
      chk("fp_second_addr", {34'd0, fp_maddr}, {34'd0, a_tab[3]});
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      chk("fp_second_ready", {60'd0, fp_rdy}, 64'h8);
      m_read = 4'b0101;
      wait_grant("fp_wait0", 1'b1, 6);
      chk("fp_m0_addr", {34'd0, fp_maddr}, {34'd0, a_tab[0]});
      chk("rr_m0_addr", {34'd0, rr_maddr}, {34'd0, a_tab[0]});
      mem_rdy = 1'b1;
      tick();
      mem_rdy = 1'b0;
      wait_grant("fp_wait_again", 1'b1, 6);
      chk("fp_repeat_addr", {34'd0, fp_maddr}, {34'd0, a_tab[0]});
      chk("rr_rotate_addr", {34'd0, rr_maddr}, {34'd0, a_tab[2]});

      // Timeout: memory silent, Error in cycle 10 after the request.
      do_reset();
      m_read = 4'b0110;
      tick();
      chk("to_grant_addr", {34'd0, rr_maddr}, {34'd0, a_tab[1]});
      for (int c = 2; c <= 9; c++) begin
         tick();
         chk($sformatf("to_c%0d_err", c), {60'd0, rr_err}, 64'd0);
         chk($sformatf("to_c%0d_mrd", c), {63'd0, rr_mrd}, 64'd1);
      end
      tick();
      chk("to_err_pulse", {60'd0, rr_err}, 64'h2);
      chk("to_no_ready", {60'd0, rr_rdy}, 64'd0);
      chk("to_mem_read_clr", {63'd0, rr_mrd}, 64'd0);
      chk("to_mem_addr_clr", {34'd0, rr_maddr}, 64'd0);
      chk("to_slice_kept", {32'd0, rr_in[63:32]}, 64'd0);
      m_read = 4'b0100;
      tick();
      chk("to_err_drop", {60'd0, rr_err}, 64'd0);
      tick();
      chk("to_next_grant", {34'd0, rr_maddr}, {34'd0, a_tab[2]});
      // Ready arriving exactly when the counter expires wins.
      for (int c = 0; c < 8; c++) begin
         tick();
         chk($sformatf("tie_c%0d_err", c), {60'd0, rr_err}, 64'd0);
      end
      mem_rdy = 1'b1; mem_in = 32'h00000077;
      tick();
      mem_rdy = 1'b0;
      chk("tie_ready", {60'd0, rr_rdy}, 64'h4);
      chk("tie_no_err", {60'd0, rr_err}, 64'd0);
      chk("tie_slice", {32'd0, rr_in[95:64]}, 64'h77);
      m_read = 4'h0;
      tick();

      // Reset in BUSY: everything cleared, no response, master 0 wins next.
      m_read = 4'b1000;
      tick();
      chk("rst_grant3", {34'd0, rr_maddr}, {34'd0, a_tab[3]});
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mem_read", {63'd0, rr_mrd}, 64'd0);
      chk("rst_mem_addr", {34'd0, rr_maddr}, 64'd0);
      chk("rst_mem_out", {32'd0, rr_mout}, 64'd0);
      chk("rst_ready", {60'd0, rr_rdy}, 64'd0);
      chk("rst_error", {60'd0, rr_err}, 64'd0);
      chk("rst_in_clear", {32'd0, rr_in[95:64]}, 64'd0);
      m_read = 4'b1001;
      tick();
      chk("rst_first_grant", {34'd0, rr_maddr}, {34'd0, a_tab[0]});
      chk("rst_no_stale_ready", {60'd0, rr_rdy}, 64'd0);
      mem_rdy = 1'b1; mem_in = 32'h0000BEEF;
      tick();
      mem_rdy = 1'b0;
      m_read  = 4'b1000;
      chk("rst_m0_ready", {60'd0, rr_rdy}, 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
